hazard_scoreboard: RTL and testbench

- Parametrised successor to the fixed E/M stall logic; tracks every in-flight register write as a (valid, addr, Tnew) entry across NSTAGE post-decode stages, counting Tnew down each cycle.
- Produces the D-stage stall and per-operand forward-source selects.
- Adds a mult/div busy counter and generalised CP0 EPC (mtc0→eret) interlock.
- Sits beside the decoder; drives the F/D freeze and D→E bubble insertion.

---
 rtl/hazard_scoreboard_pkg.sv | 28 ++
 rtl/hazard_entry_pipe.sv | 42 ++++
 rtl/hazard_scoreboard.sv | 140 ++++++++++++++
 tb/tb_hazard_scoreboard.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_scoreboard_pkg.sv
// Shared encodings for the decode-stage hazard scoreboard: result timing,
// multiply/divide start codes and CP0 register numbers.
package hazard_scoreboard_pkg;

    localparam int DEF_AW = 5;
    localparam int DEF_TW = 2;

    // Cycles from entering E until the result is available.
    localparam logic [DEF_TW-1:0] RES_NONE = 2'd0;
    localparam logic [DEF_TW-1:0] RES_ALU  = 2'd1;
    localparam logic [DEF_TW-1:0] RES_DM   = 2'd2;

    localparam logic [DEF_TW-1:0] TUSE_NONE = {DEF_TW{1'b1}};

    typedef enum logic [1:0] {
        MD_NONE = 2'b00,
        MD_MULT = 2'b01,
        MD_DIV  = 2'b10
    } md_start_e;

    localparam logic [DEF_AW-1:0] CP0_EPC = 5'd14;

    // Forward-select width: one code per tracked stage plus the register file.
    function automatic int sel_width(input int nstage);
        return (nstage < 1) ? 1 : $clog2(nstage + 1);
    endfunction

endpackage

// File: rtl/hazard_entry_pipe.sv
// Purpose: shift register of in-flight writes (valid, addr, tnew, epc), one slot per post-decode stage.
// Latency: a slot loaded at an edge is visible as stage 1 the following cycle; tnew counts down per stage.
// Backpressure: none; the pipe always advances, the caller inserts bubbles by dropping load_valid.
module hazard_entry_pipe #(
    parameter int NSTAGE = 3,
    parameter int AW     = 5,
    parameter int TW     = 2
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         load_valid,
    input  logic [AW-1:0]                load_addr,
    input  logic [TW-1:0]                load_tnew,
    input  logic                         load_epc,
    output logic [NSTAGE-1:0]            ent_valid,
    output logic [NSTAGE-1:0][AW-1:0]    ent_addr,
    output logic [NSTAGE-1:0][TW-1:0]    ent_tnew,
    output logic [NSTAGE-1:0]            ent_epc
);

    always_ff @(posedge clk) begin
        if (reset) begin
            ent_valid <= '0;
            ent_addr  <= '0;
            ent_tnew  <= '0;
            ent_epc   <= '0;
        end else begin
            // Bubbles carry zeroed fields so a stale address can never look live.
            ent_valid[0] <= load_valid;
            ent_addr[0]  <= load_valid ? load_addr : '0;
            ent_tnew[0]  <= load_valid ? load_tnew : '0;
            ent_epc[0]   <= load_valid & load_epc;
            for (int k = 1; k < NSTAGE; k++) begin
                ent_valid[k] <= ent_valid[k-1];
                ent_addr[k]  <= ent_addr[k-1];
                ent_tnew[k]  <= (ent_tnew[k-1] == '0) ? '0 : ent_tnew[k-1] - 1'b1;
                ent_epc[k]   <= ent_epc[k-1];
            end
        end
    end

endmodule

// File: rtl/hazard_scoreboard.sv
// Purpose: decode-stage interlock; register RAW stall, forward selects, MD busy and EPC->eret interlock.
// Latency: stall and forward selects are combinational from current entries and D inputs.
// Backpressure: stall freezes F/D and bubbles E; flush always wins and also inserts a bubble.
module hazard_scoreboard
    import hazard_scoreboard_pkg::*;
#(
    parameter int NSTAGE       = 3,
    parameter int AW           = 5,
    parameter int TW           = 2,
    parameter int MULT_LAT     = 5,
    parameter int DIV_LAT      = 10,
    parameter int CP0_WB_STAGE = 2
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic                                d_valid,
    input  logic [AW-1:0]                       d_rs_addr,
    input  logic [AW-1:0]                       d_rt_addr,
    input  logic [TW-1:0]                       d_tuse_rs,
    input  logic [TW-1:0]                       d_tuse_rt,
    input  logic [AW-1:0]                       d_wr_addr,
    input  logic [TW-1:0]                       d_tnew,
    input  logic                                d_md_use,
    input  logic [1:0]                          d_md_start,
    input  logic                                d_mtc0_epc,
    input  logic                                d_eret,
    input  logic                                flush,
    output logic                                stall,
    output logic [sel_width(NSTAGE)-1:0]        fwd_rs_sel,
    output logic [sel_width(NSTAGE)-1:0]        fwd_rt_sel,
    output logic                                md_busy
);

    localparam int SW      = sel_width(NSTAGE);
    localparam int MD_MAX  = (MULT_LAT > DIV_LAT) ? MULT_LAT : DIV_LAT;
    localparam int MDW     = $clog2(MD_MAX + 1);
    localparam logic [TW-1:0] TUSE_ALL = {TW{1'b1}};

    // Stages strictly before the CP0 write stage still hold an uncommitted EPC write.
    function automatic logic [NSTAGE-1:0] epc_window();
        logic [NSTAGE-1:0] m;
        m = '0;
        for (int k = 0; k < NSTAGE; k++) begin
            if (k < CP0_WB_STAGE - 1) m[k] = 1'b1;
        end
        return m;
    endfunction

    localparam logic [NSTAGE-1:0] EPC_MASK = epc_window();

    logic [NSTAGE-1:0]         ent_valid;
    logic [NSTAGE-1:0][AW-1:0] ent_addr;
    logic [NSTAGE-1:0][TW-1:0] ent_tnew;
    logic [NSTAGE-1:0]         ent_epc;

    logic                      load_valid;
    md_start_e                 s1_md;
    logic [MDW-1:0]            md_cnt;

    logic                      rs_hit, rt_hit;
    logic [SW-1:0]             rs_stage, rt_stage;
    logic [TW-1:0]             rs_tnew, rt_tnew;
    logic                      rs_stall, rt_stall, md_stall, cp0_stall;

    assign load_valid = d_valid & ~stall & ~flush;

    hazard_entry_pipe #(
        .NSTAGE (NSTAGE),
        .AW     (AW),
        .TW     (TW)
    ) u_pipe (
        .clk        (clk),
        .reset      (reset),
        .load_valid (load_valid),
        .load_addr  (d_wr_addr),
        .load_tnew  (d_tnew),
        .load_epc   (d_mtc0_epc),
        .ent_valid  (ent_valid),
        .ent_addr   (ent_addr),
        .ent_tnew   (ent_tnew),
        .ent_epc    (ent_epc)
    );

    // Scanning oldest to youngest lets the youngest match overwrite and shadow older ones.
    always_comb begin
        rs_hit   = 1'b0;
        rs_stage = '0;
        rs_tnew  = '0;
        rt_hit   = 1'b0;
        rt_stage = '0;
        rt_tnew  = '0;
        for (int k = NSTAGE - 1; k >= 0; k--) begin
            if (ent_valid[k] && ent_addr[k] != '0 && ent_addr[k] == d_rs_addr) begin
                rs_hit   = 1'b1;
                rs_stage = SW'(k + 1);
                rs_tnew  = ent_tnew[k];
            end
            if (ent_valid[k] && ent_addr[k] != '0 && ent_addr[k] == d_rt_addr) begin
                rt_hit   = 1'b1;
                rt_stage = SW'(k + 1);
                rt_tnew  = ent_tnew[k];
            end
        end
    end

    assign rs_stall   = rs_hit && (d_tuse_rs != TUSE_ALL) && (rs_tnew > d_tuse_rs);
    assign rt_stall   = rt_hit && (d_tuse_rt != TUSE_ALL) && (rt_tnew > d_tuse_rt);
    assign fwd_rs_sel = (rs_hit && rs_tnew == '0) ? rs_stage : '0;
    assign fwd_rt_sel = (rt_hit && rt_tnew == '0) ? rt_stage : '0;

    assign md_busy   = (md_cnt != '0);
    assign md_stall  = d_md_use & (md_busy | (s1_md != MD_NONE));
    assign cp0_stall = d_eret & (|(ent_valid & ent_epc & EPC_MASK));
    assign stall     = d_valid & (rs_stall | rt_stall | md_stall | cp0_stall);

    // The counter loads from the start now sitting in E, so a reload overrides any residual count.
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_md  <= MD_NONE;
            md_cnt <= '0;
        end else begin
            if (!load_valid)
                s1_md <= MD_NONE;
            else if (d_md_start == MD_MULT)
                s1_md <= MD_MULT;
            else if (d_md_start == MD_DIV)
                s1_md <= MD_DIV;
            else
                s1_md <= MD_NONE;

            if (s1_md == MD_MULT)
                md_cnt <= MDW'(MULT_LAT);
            else if (s1_md == MD_DIV)
                md_cnt <= MDW'(DIV_LAT);
            else if (md_cnt != '0)
                md_cnt <= md_cnt - 1'b1;
        end
    end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed and randomized checks of hazard_scoreboard against an age-based in-flight model.
module tb_hazard_scoreboard;
    import hazard_scoreboard_pkg::*;

    localparam int NS = 3;

    logic       clk = 1'b0;
    logic       reset;
    logic       d_valid;
    logic [4:0] d_rs_addr, d_rt_addr, d_wr_addr;
    logic [1:0] d_tuse_rs, d_tuse_rt, d_tnew, d_md_start;
    logic       d_md_use, d_mtc0_epc, d_eret, flush;
    logic       stall, md_busy;
    logic [1:0] fwd_rs_sel, fwd_rt_sel;

    int n_pass  = 0;
    int n_total = 0;

    // Model: what each stage holds, with tnew derived from the issue value and the stage depth.
    int m_v[1:NS], m_a[1:NS], m_t0[1:NS], m_epc[1:NS], m_md[1:NS];
    int cyc = 0;
    int lv = 0, lt = 0, llat = 0, pv = 0, pt = 0, plat = 0;
    int exp_stall = 0;

    hazard_scoreboard dut (
        .clk        (clk),
        .reset      (reset),
        .d_valid    (d_valid),
        .d_rs_addr  (d_rs_addr),
        .d_rt_addr  (d_rt_addr),
        .d_tuse_rs  (d_tuse_rs),
        .d_tuse_rt  (d_tuse_rt),
        .d_wr_addr  (d_wr_addr),
        .d_tnew     (d_tnew),
        .d_md_use   (d_md_use),
        .d_md_start (d_md_start),
        .d_mtc0_epc (d_mtc0_epc),
        .d_eret     (d_eret),
        .flush      (flush),
        .stall      (stall),
        .fwd_rs_sel (fwd_rs_sel),
        .fwd_rt_sel (fwd_rt_sel),
        .md_busy    (md_busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s actual=%0d expected=%0d (t=%0t)", name, act, exp, $time);
    endtask

    function automatic int tn(input int k);
        return (m_t0[k] > k - 1) ? m_t0[k] - (k - 1) : 0;
    endfunction

    function automatic int youngest(input int a);
        for (int k = 1; k <= NS; k++)
            if (m_v[k] != 0 && m_a[k] != 0 && m_a[k] == a) return k;
        return 0;
    endfunction

    function automatic int model_busy();
        if (lv != 0 && cyc >= lt + 1 && cyc <= lt + llat) return 1;
        if (pv != 0 && cyc >= pt + 1 && cyc <= pt + plat && cyc <= lt) return 1;
        return 0;
    endfunction

    task automatic model_compare();
        int ys, yt, rs_st, rt_st, md_st, cp_st, e_rs, e_rt, busy;
        ys    = youngest(int'(d_rs_addr));
        yt    = youngest(int'(d_rt_addr));
        rs_st = (d_tuse_rs != TUSE_NONE && ys != 0 && tn(ys) > int'(d_tuse_rs)) ? 1 : 0;
        rt_st = (d_tuse_rt != TUSE_NONE && yt != 0 && tn(yt) > int'(d_tuse_rt)) ? 1 : 0;
        e_rs  = (ys != 0 && tn(ys) == 0) ? ys : 0;
        e_rt  = (yt != 0 && tn(yt) == 0) ? yt : 0;
        busy  = model_busy();
        md_st = (d_md_use && (busy != 0 || (m_v[1] != 0 && m_md[1] != 0))) ? 1 : 0;
        cp_st = (d_eret && m_v[1] != 0 && m_epc[1] != 0) ? 1 : 0;
        exp_stall = (d_valid && (rs_st + rt_st + md_st + cp_st) != 0) ? 1 : 0;
        chk("stall", int'(stall), exp_stall);
        chk("fwd_rs_sel", int'(fwd_rs_sel), e_rs);
        chk("fwd_rt_sel", int'(fwd_rt_sel), e_rt);
        chk("md_busy", int'(md_busy), busy);
    endtask

    task automatic model_update();
        int load, md;
        cyc++;
        if (reset) begin
            for (int k = 1; k <= NS; k++) begin
                m_v[k] = 0; m_a[k] = 0; m_t0[k] = 0; m_epc[k] = 0; m_md[k] = 0;
            end
            lv = 0; pv = 0;
        end else begin
            for (int k = NS; k > 1; k--) begin
                m_v[k] = m_v[k-1]; m_a[k] = m_a[k-1]; m_t0[k] = m_t0[k-1];
                m_epc[k] = m_epc[k-1]; m_md[k] = m_md[k-1];
            end
            load   = (d_valid && exp_stall == 0 && !flush) ? 1 : 0;
            md     = load ? int'(d_md_start) : 0;
            m_v[1] = load; m_a[1] = int'(d_wr_addr); m_t0[1] = int'(d_tnew);
            m_epc[1] = int'(d_mtc0_epc); m_md[1] = md;
            if (md == 1 || md == 2) begin
                pv = lv; pt = lt; plat = llat;
                lv = 1; lt = cyc; llat = (md == 1) ? 5 : 10;
            end
        end
    endtask

    task automatic settle();
        @(negedge clk);
        model_compare();
    endtask

    task automatic advance();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic idle();
        d_valid = 0; d_rs_addr = 0; d_rt_addr = 0; d_tuse_rs = TUSE_NONE; d_tuse_rt = TUSE_NONE;
        d_wr_addr = 0; d_tnew = RES_NONE; d_md_use = 0; d_md_start = MD_NONE;
        d_mtc0_epc = 0; d_eret = 0; flush = 0;
    endtask

    task automatic drain();
        idle();
        for (int i = 0; i < 4; i++) begin settle(); advance(); end
    endtask

    task automatic issue_write(input int wr, input int tnew);
        idle(); d_valid = 1; d_wr_addr = 5'(wr); d_tnew = 2'(tnew);
    endtask

    task automatic issue_read_rs(input int rs, input int tuse);
        idle(); d_valid = 1; d_rs_addr = 5'(rs); d_tuse_rs = 2'(tuse);
    endtask

    initial begin
        int n;
        idle();
        reset = 1;
        advance(); advance();
        reset = 0;
        settle();
        chk("reset_stall", int'(stall), 0);
        chk("reset_fwd_rs", int'(fwd_rs_sel), 0);
        chk("reset_fwd_rt", int'(fwd_rt_sel), 0);
        chk("reset_md_busy", int'(md_busy), 0);
        advance();

        // Load-use: lw $8 then a consumer needing it in E.
        issue_write(8, RES_DM); settle(); advance();
        issue_read_rs(8, 1); d_wr_addr = 10; d_tnew = RES_ALU;
        settle(); chk("loaduse_stall_c1", int'(stall), 1); advance();
        settle(); chk("loaduse_stall_c2", int'(stall), 0); advance();
        drain();

        // ALU result feeding a branch compare in D.
        issue_write(9, RES_ALU); settle(); advance();
        issue_read_rs(9, 0);
        settle(); chk("alu_stall_c1", int'(stall), 1); advance();
        settle(); chk("alu_stall_c2", int'(stall), 0); chk("alu_fwd_m", int'(fwd_rs_sel), 2); advance();
        drain();

        // $0 never stalls or forwards.
        issue_write(0, RES_DM); settle(); advance();
        idle(); d_valid = 1; d_tuse_rs = 0; d_tuse_rt = 0;
        settle(); chk("zero_stall", int'(stall), 0); chk("zero_fwd_rs", int'(fwd_rs_sel), 0);
        chk("zero_fwd_rt", int'(fwd_rt_sel), 0); advance();
        drain();

        // Two writes to $5; the younger one in E wins.
        issue_write(5, RES_ALU); settle(); advance();
        issue_write(5, RES_NONE); settle(); advance();
        issue_read_rs(5, 0); d_rt_addr = 5; d_tuse_rt = 0;
        settle(); chk("shadow_fwd_rs", int'(fwd_rs_sel), 1); chk("shadow_fwd_rt", int'(fwd_rt_sel), 1);
        chk("shadow_stall", int'(stall), 0); advance();
        drain();

        // mult followed by mflo.
        idle(); d_valid = 1; d_md_use = 1; d_md_start = MD_MULT; settle(); advance();
        idle(); d_valid = 1; d_md_use = 1; d_wr_addr = 8; d_tnew = RES_ALU;
        n = 0;
        for (int i = 0; i < 20; i++) begin
            settle();
            if (!stall) break;
            n++;
            advance();
        end
        chk("md_stall_cycles", n, 6);
        chk("md_release_busy", int'(md_busy), 0);
        advance();
        drain();

        // mtc0 EPC then eret.
        idle(); d_valid = 1; d_mtc0_epc = 1; settle(); advance();
        idle(); d_valid = 1; d_eret = 1;
        settle(); chk("epc_stall_c1", int'(stall), 1); advance();
        settle(); chk("epc_stall_c2", int'(stall), 0); advance();
        drain();
        idle(); d_valid = 1; settle(); advance();
        idle(); d_valid = 1; d_eret = 1;
        settle(); chk("cp0_reg12_stall", int'(stall), 0); advance();
        drain();

        // Flush during a stalled load-use, then flush of a non-stalled producer.
        issue_write(8, RES_DM); settle(); advance();
        issue_read_rs(8, 1); d_wr_addr = 10; d_tnew = RES_ALU; flush = 1;
        settle(); chk("flush_stall_still", int'(stall), 1); advance();
        issue_read_rs(10, 0);
        settle(); chk("flush_bubble_stall", int'(stall), 0); advance();
        issue_write(11, RES_ALU); flush = 1; settle(); advance();
        issue_read_rs(11, 0);
        settle(); chk("flush_producer_stall", int'(stall), 0); advance();
        idle(); d_valid = 1; d_md_use = 1; d_md_start = MD_DIV; flush = 1; settle(); advance();
        idle(); d_valid = 1; d_md_use = 1;
        settle(); chk("flushed_div_stall", int'(stall), 0); chk("flushed_div_busy", int'(md_busy), 0); advance();
        drain();

        // Reset in the middle of a divide.
        idle(); d_valid = 1; d_md_use = 1; d_md_start = MD_DIV; settle(); advance();
        idle();
        for (int i = 0; i < 3; i++) begin settle(); advance(); end
        d_valid = 1; d_md_use = 1;
        settle(); chk("div_busy_before_reset", int'(md_busy), 1); chk("div_stall_before_reset", int'(stall), 1);
        reset = 1; advance(); reset = 0;
        settle(); chk("div_busy_after_reset", int'(md_busy), 0); chk("div_stall_after_reset", int'(stall), 0);
        advance();
        drain();

        // Randomized traffic over a small register set so matches are frequent.
        for (int i = 0; i < 3000; i++) begin
            d_valid    = ($urandom_range(0, 7) != 0);
            d_rs_addr  = 5'($urandom_range(0, 3));
            d_rt_addr  = 5'($urandom_range(0, 3));
            d_tuse_rs  = 2'($urandom_range(0, 3));
            d_tuse_rt  = 2'($urandom_range(0, 3));
            d_wr_addr  = 5'($urandom_range(0, 3));
            d_tnew     = 2'($urandom_range(0, 2));
            d_md_use   = ($urandom_range(0, 5) == 0);
            n          = $urandom_range(0, 15);
            d_md_start = (n == 0) ? MD_MULT : (n == 1) ? MD_DIV : MD_NONE;
            d_mtc0_epc = ($urandom_range(0, 7) == 0);
            d_eret     = ($urandom_range(0, 7) == 0);
            flush      = ($urandom_range(0, 9) == 0);
            reset      = ($urandom_range(0, 249) == 0);
            settle();
            advance();
        end
        reset = 0;
        idle();
        settle();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
